// File: rtl/qam16_pkg.sv
// Shared definitions for the 16-QAM transmitter: Gray level codes, level mapping, stage state encoding.
package qam16_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    // Signed constellation level for a 2-bit Gray code, wrapped to lvl_w bits two's complement.
    function automatic logic signed [31:0] map_level(input logic [1:0] code, input int amp,
                                                     input int lvl_w);
        int v;
        int sh;
        case (code)
            LVL_M3:  v = -3 * amp;
            LVL_M1:  v = -amp;
            LVL_P1:  v = amp;
            default: v = 3 * amp;
        endcase
        sh = 32 - lvl_w;
        return (v <<< sh) >>> sh;
    endfunction

endpackage

// File: rtl/qam16_sym_fifo.sv
// Two-entry synchronous nibble FIFO; registered head, no fall-through, synchronous clear.
module qam16_sym_fifo #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            do_push = push && !full;
            do_pop  = pop && !empty;
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);

endmodule

// File: rtl/qam16_symbol_mapper.sv
// 16-QAM symbol mapper: buffers nibbles, Gray-maps them to I/Q and emits SPS samples per symbol.
module qam16_symbol_mapper
    import qam16_pkg::*;
#(
    parameter int unsigned SPS        = 4,
    parameter int unsigned LVL_W      = 8,
    parameter int unsigned AMP        = 16,
    parameter int unsigned ZERO_STUFF = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              sym_in,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic                    sample_en,
    output logic signed [LVL_W-1:0] i_out,
    output logic signed [LVL_W-1:0] q_out,
    output logic                    out_valid,
    output logic                    sym_first,
    output logic                    underrun
);

    localparam int unsigned     CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [LVL_W-1:0] i_q, i_d;
    logic signed [LVL_W-1:0] q_q, q_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sym_first_q, sym_first_d;
    logic                    underrun_q, underrun_d;

    logic       fifo_push, fifo_pop, fifo_clear;
    logic [3:0] fifo_head;
    logic [1:0] fifo_count;
    logic       fifo_full, fifo_empty;

    // A push coinciding with start is dropped along with the FIFO contents.
    assign sym_ready = (state_q == RUN) && !fifo_full;
    assign fifo_push = sym_valid && sym_ready && !start;

    qam16_sym_fifo #(.W(4)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (sym_in),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            i_q         <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
            sym_first_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
            sym_first_q <= sym_first_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_d         = i_q;
        q_d         = q_q;
        out_valid_d = 1'b0;
        sym_first_d = 1'b0;
        underrun_d  = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clear  = 1'b0;
        if (start) begin
            state_d    = RUN;
            cnt_d      = '0;
            i_d        = '0;
            q_d        = '0;
            fifo_clear = 1'b1;
        end else if (state_q == RUN && sample_en) begin
            out_valid_d = 1'b1;
            if (cnt_q == '0) begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    i_d         = LVL_W'(map_level(fifo_head[3:2], int'(AMP), int'(LVL_W)));
                    q_d         = LVL_W'(map_level(fifo_head[1:0], int'(AMP), int'(LVL_W)));
                    sym_first_d = 1'b1;
                    cnt_d       = CNT_LOAD;
                end else begin
                    i_d        = '0;
                    q_d        = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
                if (ZERO_STUFF != 0) begin
                    i_d = '0;
                    q_d = '0;
                end
            end
        end
    end

    assign i_out     = i_q;
    assign q_out     = q_q;
    assign out_valid = out_valid_q;
    assign sym_first = sym_first_q;
    assign underrun  = underrun_q;

endmodule
